// File: rtl/lemming_world_if.sv
// lemming_world_if: lemming <-> world signal bundle. master = lemming side (walk/aaah), slave = world side (bumps/ground).
interface lemming_world_if;
  logic walk_left;
  logic walk_right;
  logic aaah;
  logic bump_left;
  logic bump_right;
  logic ground;
  modport master (output walk_left, walk_right, aaah, input bump_left, bump_right, ground);
  modport slave (input walk_left, walk_right, aaah, output bump_left, bump_right, ground);
endinterface

// File: rtl/lemming_world.sv
// lemming_world: 1-D track environment (walls, self-filling holes) closing the loop around a walking-lemming FSM.
// Ports: clk, areset (async, active-high); lem = lemming bundle (walk_left/walk_right/aaah in, bump_left/bump_right/ground out);
// pos = lemming cell, falling = world in DROP, fall_count/step_count = saturating statistics, proto_err = sticky protocol violation.
module lemming_world #(
  parameter int TRACK_LEN = 16,
  parameter int POS_W = 4,
  parameter int START_POS = 8,
  parameter logic [TRACK_LEN-1:0] HOLE_MAP = 16'h0204,
  parameter int FALL_CYCLES = 3
) (
  input  logic             clk,
  input  logic             areset,
  lemming_world_if.slave   lem,
  output logic [POS_W-1:0] pos,
  output logic             falling,
  output logic [7:0]       fall_count,
  output logic [15:0]      step_count,
  output logic             proto_err
);
  typedef enum logic {STAND, DROP} state_t;
  localparam logic [TRACK_LEN-1:0] HOLE_INIT = HOLE_MAP & ~(TRACK_LEN'(1) << START_POS);
  localparam logic [POS_W-1:0] LAST = POS_W'(TRACK_LEN - 1);
  localparam logic [7:0] FALL_LAST = 8'(FALL_CYCLES - 1);
  state_t state;
  logic [TRACK_LEN-1:0] hole;
  logic [7:0] fall_cnt;
  logic multi, walking, go_left, go_right, move;
  logic [POS_W-1:0] next_pos;
  always_comb begin
    walking = lem.walk_left | lem.walk_right;
    multi = (lem.walk_left & lem.walk_right) | (walking & lem.aaah);
    go_left = state == STAND & !multi & lem.walk_left & pos != '0;
    go_right = state == STAND & !multi & lem.walk_right & pos != LAST;
    move = go_left | go_right;
    next_pos = go_left ? pos - POS_W'(1) : pos + POS_W'(1);
  end
  assign lem.ground = state == STAND;
  assign lem.bump_left = state == STAND & lem.walk_left & pos == '0;
  assign lem.bump_right = state == STAND & lem.walk_right & pos == LAST;
  assign falling = state == DROP;
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state <= STAND;
      pos <= POS_W'(START_POS);
      hole <= HOLE_INIT;
      fall_cnt <= '0;
      fall_count <= '0;
      step_count <= '0;
      proto_err <= 1'b0;
    end else begin
      // the lemming gets exactly one DROP cycle to notice the missing ground
      if (multi | (state == DROP & walking & fall_cnt != '0)) proto_err <= 1'b1;
      if (state == STAND) begin
        if (move) begin
          pos <= next_pos;
          step_count <= step_count + 16'(step_count != '1);
          if (hole[next_pos]) begin
            state <= DROP;
            fall_cnt <= '0;
          end
        end
      end else begin
        fall_cnt <= fall_cnt + 8'd1;
        if (fall_cnt == FALL_LAST) begin
          hole[pos] <= 1'b0;
          fall_count <= fall_count + 8'(fall_count != '1);
          state <= STAND;
        end
      end
    end
  end
endmodule

// File: tb/tb_lemming_world.sv
// tb_lemming_world: randomized and directed checks of lemming_world against a track-level reference model.
module tb_lemming_world;
  localparam int LEN = 16;
  localparam int FALL = 3;
  logic clk = 1'b0;
  logic areset = 1'b0;
  logic [3:0] pos;
  logic falling, proto_err;
  logic [7:0] fall_count;
  logic [15:0] step_count;
  int vecs = 0;
  int errs = 0;
  int mpos, mdrop, mfalls, msteps;
  bit merr;
  bit [15:0] mhole;
  bit s_ground, s_bl, s_br;
  always #5 clk = ~clk;
  lemming_world_if lif();
  lemming_world dut (
    .clk(clk), .areset(areset), .lem(lif), .pos(pos), .falling(falling),
    .fall_count(fall_count), .step_count(step_count), .proto_err(proto_err)
  );
  function void mreset();
    mpos = 8;
    mdrop = 0;
    mfalls = 0;
    msteps = 0;
    merr = 0;
    mhole = 16'h0204 & ~(16'h1 << 8);
  endfunction
  // mdrop counts remaining ground-less cycles; FALL means the first DROP cycle
  function void mstep(bit l, bit r, bit a);
    int n, t;
    n = int'(l) + int'(r) + int'(a);
    if (n > 1) merr = 1;
    if (mdrop > 0) begin
      if ((l | r) && mdrop != FALL) merr = 1;
      mdrop--;
      if (mdrop == 0) begin
        mhole[mpos] = 0;
        if (mfalls < 255) mfalls++;
      end
    end else if (n == 1 && (l | r)) begin
      t = r ? mpos + 1 : mpos - 1;
      if (t >= 0 && t < LEN) begin
        mpos = t;
        if (msteps < 65535) msteps++;
        if (mhole[mpos]) mdrop = FALL;
      end
    end
  endfunction
  function logic [32:0] expv();
    bit g;
    g = mdrop == 0;
    return {4'(mpos), g, g && lif.walk_left && mpos == 0, g && lif.walk_right && mpos == LEN - 1,
            !g, 8'(mfalls), 16'(msteps), merr};
  endfunction
  function logic [32:0] obsv();
    return {pos, lif.ground, lif.bump_left, lif.bump_right, falling, fall_count, step_count, proto_err};
  endfunction
  task automatic step(input bit l, input bit r, input bit a);
    lif.walk_left = l;
    lif.walk_right = r;
    lif.aaah = a;
    @(negedge clk);
    s_ground = lif.ground;
    s_bl = lif.bump_left;
    s_br = lif.bump_right;
    @(posedge clk);
    mstep(l, r, a);
    #1;
  endtask
  task automatic do_reset();
    {lif.walk_left, lif.walk_right, lif.aaah} = 3'b000;
    areset = 1'b1;
    mreset();
    @(negedge clk);
    areset = 1'b0;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    {lif.walk_left, lif.walk_right, lif.aaah} = 3'b000;
    areset = 1'b1;
    mreset();
    #2;
    vecs++;
    if (obsv() !== {4'd8, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 16'd0, 1'b0}) begin
      errs++;
      $display("FAIL reset_state: got %h expected %h", obsv(), {4'd8, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 16'd0, 1'b0});
    end
    @(negedge clk);
    areset = 1'b0;
    @(posedge clk);
    #1;
    vecs++;
    if (obsv() !== expv()) begin
      errs++;
      $display("FAIL reset_release: got %h expected %h", obsv(), expv());
    end
  endtask
  task automatic test_fall();
    step(0, 1, 0);
    vecs++;
    if ({pos, lif.ground, falling} !== {4'd9, 1'b0, 1'b1}) begin
      errs++;
      $display("FAIL fall_enter: got %h expected %h", {pos, lif.ground, falling}, {4'd9, 1'b0, 1'b1});
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1);
      vecs++;
      if (obsv() !== expv()) begin
        errs++;
        $display("FAIL fall_cycle%0d: got %h expected %h", i, obsv(), expv());
      end
    end
    vecs++;
    if ({pos, lif.ground, fall_count} !== {4'd9, 1'b1, 8'd1}) begin
      errs++;
      $display("FAIL fall_land: got %h expected %h", {pos, lif.ground, fall_count}, {4'd9, 1'b1, 8'd1});
    end
  endtask
  task automatic test_walk_right();
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 0);
      vecs++;
      if (obsv() !== expv()) begin
        errs++;
        $display("FAIL walk_right%0d: got %h expected %h", i, obsv(), expv());
      end
    end
    step(0, 1, 0);
    vecs++;
    if ({pos, lif.bump_right, step_count} !== {4'd15, 1'b1, 16'd7}) begin
      errs++;
      $display("FAIL right_wall: got %h expected %h", {pos, lif.bump_right, step_count}, {4'd15, 1'b1, 16'd7});
    end
  endtask
  task automatic test_walk_left();
    for (int i = 0; i < 13; i++) begin
      step(1, 0, 0);
      vecs++;
      if (obsv() !== expv()) begin
        errs++;
        $display("FAIL walk_left%0d: got %h expected %h", i, obsv(), expv());
      end
    end
    vecs++;
    if ({pos, lif.ground} !== {4'd2, 1'b0}) begin
      errs++;
      $display("FAIL hole2_drop: got %h expected %h", {pos, lif.ground}, {4'd2, 1'b0});
    end
    for (int i = 0; i < 6; i++) begin
      if (i < 3) step(0, 0, 1);
      else step(1, 0, 0);
      vecs++;
      if (obsv() !== expv()) begin
        errs++;
        $display("FAIL left_tail%0d: got %h expected %h", i, obsv(), expv());
      end
    end
    vecs++;
    if ({pos, lif.bump_left, fall_count, step_count} !== {4'd0, 1'b1, 8'd2, 16'd22}) begin
      errs++;
      $display("FAIL left_wall: got %h expected %h", {pos, lif.bump_left, fall_count, step_count},
               {4'd0, 1'b1, 8'd2, 16'd22});
    end
  endtask
  task automatic test_proto();
    for (int i = 0; i < 5; i++) step(0, 1, 0);
    step(1, 1, 0);
    vecs++;
    if ({pos, proto_err} !== {4'd5, 1'b1}) begin
      errs++;
      $display("FAIL proto_set: got %h expected %h", {pos, proto_err}, {4'd5, 1'b1});
    end
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0);
      vecs++;
      if (obsv() !== expv()) begin
        errs++;
        $display("FAIL proto_sticky%0d: got %h expected %h", i, obsv(), expv());
      end
    end
  endtask
  task automatic test_reset_mid_drop();
    do_reset();
    step(0, 1, 0);
    step(0, 0, 1);
    {lif.walk_left, lif.walk_right, lif.aaah} = 3'b000;
    areset = 1'b1;
    mreset();
    #1;
    vecs++;
    if ({pos, lif.ground, fall_count} !== {4'd8, 1'b1, 8'd0}) begin
      errs++;
      $display("FAIL async_reset: got %h expected %h", {pos, lif.ground, fall_count}, {4'd8, 1'b1, 8'd0});
    end
    @(negedge clk);
    areset = 1'b0;
    @(posedge clk);
    #1;
    step(0, 1, 0);
    vecs++;
    if ({pos, lif.ground} !== {4'd9, 1'b0}) begin
      errs++;
      $display("FAIL hole_reopen: got %h expected %h", {pos, lif.ground}, {4'd9, 1'b0});
    end
    for (int i = 0; i < 3; i++) step(0, 0, 1);
  endtask
  task automatic test_closed_loop();
    int ls;
    ls = 0;
    do_reset();
    for (int i = 0; i < 80; i++) begin
      step(ls == 0, ls == 1, ls >= 2);
      vecs++;
      if (obsv() !== expv()) begin
        errs++;
        $display("FAIL loop%0d: got %h expected %h", i, obsv(), expv());
      end
      case (ls)
        0: ls = !s_ground ? 2 : s_bl ? 1 : 0;
        1: ls = !s_ground ? 3 : s_br ? 0 : 1;
        2: ls = s_ground ? 0 : 2;
        default: ls = s_ground ? 1 : 3;
      endcase
    end
    vecs++;
    if ({proto_err, fall_count} !== {1'b0, 8'd2}) begin
      errs++;
      $display("FAIL loop_end: got %h expected %h", {proto_err, fall_count}, {1'b0, 8'd2});
    end
  endtask
  task automatic test_random();
    int r;
    bit [2:0] v;
    for (int b = 0; b < 4; b++) begin
      do_reset();
      for (int i = 0; i < 150; i++) begin
        r = $urandom_range(0, 15);
        if (r == 0) begin
          case ($urandom_range(0, 2))
            0: v = 3'b011;
            1: v = 3'b101;
            default: v = 3'b110;
          endcase
        end else if (r < 3) v = 3'b000;
        else v = 3'b001 << $urandom_range(0, 2);
        step(v[2], v[1], v[0]);
        vecs++;
        if (obsv() !== expv()) begin
          errs++;
          $display("FAIL random%0d_%0d: got %h expected %h", b, i, obsv(), expv());
        end
      end
    end
  endtask
  initial begin
    {lif.walk_left, lif.walk_right, lif.aaah} = 3'b000;
    test_reset();
    test_fall();
    test_walk_right();
    test_walk_left();
    test_proto();
    test_reset_mid_drop();
    test_closed_loop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
